// File: rtl/trace_fabric_mgmt_deser.sv
// trace_fabric_mgmt_deser
//
// Deserializes the fabric management channel's 1-bit, 4-channel stream into
// WORD_W-bit words. Bits arrive LSB-first. Each channel keeps its own
// accumulator and bit counter. Completed words leave through a 2-entry
// output FIFO, tagged with their channel.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_ready     sink ready (registered)
//   in_valid     sink beat valid
//   in_data      serial management bit
//   in_channel   channel of in_data (0..3)
//   out_ready    source backpressure
//   out_valid    FIFO head valid
//   out_data     assembled word; bit 0 is the first bit received
//   out_channel  channel of out_data
//
// Handshake: a beat transfers on a rising edge where valid && ready are
// both high. The producer holds valid and payload stable until that edge.
// valid never drops without a transfer.
module trace_fabric_mgmt_deser #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic              in_data,
  input  logic [1:0]        in_channel,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        out_channel
);

  localparam int CW = $clog2(WORD_W);
  localparam int EW = WORD_W + 2;

  logic [WORD_W-1:0] acc_q [4];
  logic [WORD_W-1:0] acc_d [4];
  logic [CW-1:0]     cnt_q [4];
  logic [CW-1:0]     cnt_d [4];
  logic [EW-1:0]     ent_q [2];
  logic [EW-1:0]     ent_d [2];
  logic [1:0]        count_q, count_d;
  logic              in_ready_q, in_ready_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] shifted;

  always_comb begin
    accept  = in_valid && in_ready_q;
    shifted = {in_data, acc_q[in_channel][WORD_W-1:1]};
    push    = accept && (cnt_q[in_channel] == CW'(WORD_W - 1));
    pop     = (count_q != 2'd0) && out_ready;

    for (int c = 0; c < 4; c++) begin
      acc_d[c] = acc_q[c];
      cnt_d[c] = cnt_q[c];
    end
    if (accept) begin
      acc_d[in_channel] = shifted;
      cnt_d[in_channel] = push ? '0 : cnt_q[in_channel] + CW'(1);
    end

    // Shift FIFO: entry 0 is always the head. A pop moves entry 1 down;
    // a push lands in the first slot left free after that shift.
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    if (pop) ent_d[0] = ent_q[1];
    if (push) begin
      if ((count_q == 2'd1) && !pop) ent_d[1] = {in_channel, shifted};
      else                           ent_d[0] = {in_channel, shifted};
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};
    // Conservative: any beat may complete a word, so stall whenever full.
    in_ready_d = (count_d <= 2'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        acc_q[c] <= acc_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      ent_q[0]   <= ent_d[0];
      ent_q[1]   <= ent_d[1];
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = ent_q[0][WORD_W-1:0];
  assign out_channel = ent_q[0][EW-1:WORD_W];

endmodule

// File: tb/tb_trace_fabric_mgmt_deser.sv
// Bench for trace_fabric_mgmt_deser (WORD_W = 8). The reference model keeps
// a list of received bits per channel and a queue of completed,
// not-yet-popped words. Its ready flag follows the rule "at most one word
// waiting after the previous edge".
module tb_trace_fabric_mgmt_deser;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_ready;
  logic         in_valid = 1'b0;
  logic         in_data = 1'b0;
  logic [1:0]   in_channel = 2'd0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_channel;

  trace_fabric_mgmt_deser #(.WORD_W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_channel(in_channel),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard / reference model
  logic [W+1:0] exp_q[$];
  int           nbits [4];
  logic [31:0]  partial [4];
  logic         m_rdy = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic model_clear();
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      nbits[c] = 0;
      partial[c] = 32'd0;
    end
    m_rdy = 1'b0;
  endtask

  // Driver: applies one cycle of input, updates the model at the edge and
  // returns 1 time unit after the edge.
  task automatic step(input logic v, input logic d, input logic [1:0] ch,
                      input logic ordy);
    logic acc_m, pop_m;
    in_valid = v; in_data = d; in_channel = ch; out_ready = ordy;
    acc_m = v && m_rdy;
    pop_m = (exp_q.size() != 0) && ordy;
    @(posedge clk);
    if (pop_m) void'(exp_q.pop_front());
    if (acc_m) begin
      partial[ch] = partial[ch] | (32'(d) << nbits[ch]);
      nbits[ch]++;
      if (nbits[ch] == W) begin
        exp_q.push_back({ch, partial[ch][W-1:0]});
        nbits[ch] = 0;
        partial[ch] = 32'd0;
      end
    end
    m_rdy = (exp_q.size() <= 1);
    #1;
  endtask

  task automatic test_reset();
    model_clear();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_data, out_channel} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h ch=%0d, want all 0",
               in_ready, out_valid, out_data, out_channel);
    end
    reset_n = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b1);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, w[i], 2'd0, 1'b1);
      n_vec++;
      if (out_valid !== (i == 7)) begin
        n_err++;
        $display("FAIL single_valid bit%0d: got %b want %b", i, out_valid, (i == 7));
      end
    end
    n_vec++;
    if (out_data !== 8'hA5 || out_channel !== 2'd0) begin
      n_err++;
      $display("FAIL single_word: got ch%0d %h want ch0 a5", out_channel, out_data);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_one_cycle: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_interleave();
    logic [7:0] a = 8'h3C;
    logic [7:0] b = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, a[i], 2'd1, 1'b1);
      if (i == 7) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_channel !== 2'd1) begin
          n_err++;
          $display("FAIL interleave_ch1: got v%b ch%0d %h want v1 ch1 3c",
                   out_valid, out_channel, out_data);
        end
      end
      step(1'b1, b[i], 2'd2, 1'b1);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_channel !== 2'd2) begin
      n_err++;
      $display("FAIL interleave_ch2: got v%b ch%0d %h want v1 ch2 f0",
               out_valid, out_channel, out_data);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] w0 = 8'h11;
    logic [7:0] w1 = 8'h22;
    logic [7:0] w2 = 8'h33;
    for (int i = 0; i < 8; i++) step(1'b1, w0[i], 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, w1[i], 2'd3, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_err++;
      $display("FAIL bp_full: got rdy=%b v=%b %h want rdy=0 v=1 11",
               in_ready, out_valid, out_data);
    end
    // Third word's first bit is presented but must not be taken.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, w2[0], 2'd1, 1'b0);
      n_vec++;
      if (in_ready !== 1'b0 || out_data !== 8'h11 || out_channel !== 2'd0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got rdy=%b ch%0d %h want rdy=0 ch0 11",
                 k, in_ready, out_channel, out_data);
      end
    end
    step(1'b1, w2[0], 2'd1, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h22 || out_channel !== 2'd3) begin
      n_err++;
      $display("FAIL bp_pop1: got v%b ch%0d %h want v1 ch3 22",
               out_valid, out_channel, out_data);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, w2[i], 2'd1, 1'b1);
      n_vec++;
      if (in_ready !== m_rdy) begin
        n_err++;
        $display("FAIL bp_ready bit%0d: got %b want %b", i, in_ready, m_rdy);
      end
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h33 || out_channel !== 2'd1) begin
      n_err++;
      $display("FAIL bp_third: got v%b ch%0d %h want v1 ch1 33",
               out_valid, out_channel, out_data);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_push_pop();
    logic [7:0] a = 8'h96;
    logic [7:0] b = 8'h4B;
    for (int i = 0; i < 8; i++) step(1'b1, a[i], 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, b[i], 2'd2, (i == 7));
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL pp_ready bit%0d: got %b want 1", i, in_ready);
      end
    end
    n_vec++;
    if (exp_q.size() != 1 || out_valid !== 1'b1 || out_data !== 8'h4B || out_channel !== 2'd2) begin
      n_err++;
      $display("FAIL pp_head: got v%b ch%0d %h want v1 ch2 4b (model depth %0d)",
               out_valid, out_channel, out_data, exp_q.size());
    end
    step(1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] w = 8'h5A;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'd0, 1'b1);
    reset_n = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_data, out_channel} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b data=%h ch=%0d want all 0",
               in_ready, out_valid, out_data, out_channel);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, w[i], 2'd0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_channel !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_word: got v%b ch%0d %h want v1 ch0 5a",
               out_valid, out_channel, out_data);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    int popped = 0;
    for (int n = 0; n < 10000; n++) begin
      logic ordy;
      ordy = ($urandom_range(0, 9) < 6);
      if (ordy && exp_q.size() != 0) popped++;
      step(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), ordy);
      n_vec++;
      if (out_valid !== (exp_q.size() != 0) || in_ready !== m_rdy) begin
        n_err++;
        $display("FAIL rand_hs cyc%0d: got v%b rdy%b want v%b rdy%b",
                 n, out_valid, in_ready, (exp_q.size() != 0), m_rdy);
      end
      if (exp_q.size() != 0) begin
        n_vec++;
        if ({out_channel, out_data} !== exp_q[0]) begin
          n_err++;
          $display("FAIL rand_head cyc%0d: got ch%0d %h want ch%0d %h",
                   n, out_channel, out_data, exp_q[0][W+1:W], exp_q[0][W-1:0]);
        end
      end
    end
    n_vec++;
    if (popped < 100) begin
      n_err++;
      $display("FAIL rand_activity: got %0d words popped want at least 100", popped);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_interleave();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
